// File: rtl/imm_gen_pipe_pkg.sv
// Shared formats, opcode constants and defaults for the decode-stage immediate generator.
// Pure declarations: no logic, no latency, no flow control.
package imm_gen_pipe_pkg;

  localparam int INSTR_LEN_DEF = 32;
  localparam int WORD_DEF      = 64;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_B    = 3'd1,
    FMT_CB   = 3'd2,
    FMT_D    = 3'd3,
    FMT_I    = 3'd4,
    FMT_IW   = 3'd5
  } fmt_e;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;

  // A MOVZ half-word slot must land entirely inside the output word.
  function automatic logic iw_fits(input logic [1:0] hw, input int word);
    return ((int'(hw) * 16) + 16) <= word;
  endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational opcode classifier (instruction[31:21] -> format), first match wins.
// Zero latency, no flow control.
module imm_fmt_decode
  import imm_gen_pipe_pkg::*;
(
  input  logic [10:0] opcode,
  output fmt_e        fmt
);

  always_comb begin
    fmt = FMT_NONE;
    if (opcode[10:5] == OP_B || opcode[10:5] == OP_BL)
      fmt = FMT_B;
    else if (opcode[10:3] == OP_CBZ || opcode[10:3] == OP_CBNZ || opcode[10:3] == OP_BCOND)
      fmt = FMT_CB;
    else if (opcode == OP_LDUR || opcode == OP_STUR)
      fmt = FMT_D;
    else if (opcode[10:1] == OP_ADDI || opcode[10:1] == OP_SUBI ||
             opcode[10:1] == OP_ANDI || opcode[10:1] == OP_ORRI)
      fmt = FMT_I;
    else if (opcode[10:2] == OP_MOVZ)
      fmt = FMT_IW;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: classify, extend/shift to WORD bits; STAGES cycles latency.
// Valid/ready both sides; stages hold under out_ready low, in_ready never depends on in_valid.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int INSTR_LEN    = INSTR_LEN_DEF,
  parameter int WORD         = WORD_DEF,
  parameter int STAGES       = 1,
  parameter int SHIFT_BRANCH = 0,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] instruction,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      imm_out,
  output logic [2:0]           fmt_out,
  output logic                 illegal,
  output logic [CNT_W-1:0]     illegal_count
);

  fmt_e            dec_fmt;
  fmt_e            ext_fmt;
  logic [25:0]     ext_payload;
  logic [WORD-1:0] ext_imm;
  logic            ext_ill;
  logic            fin_src_vld;
  logic            out_adv;

  imm_fmt_decode u_fmt_decode (
    .opcode (instruction[31:21]),
    .fmt    (dec_fmt)
  );

  assign out_adv = !out_valid || out_ready;

  generate
    if (STAGES == 2) begin : g_two_stage
      logic        s0_valid;
      fmt_e        s0_fmt;
      logic [25:0] s0_payload;
      logic        s0_advance;

      assign s0_advance = s0_valid && out_adv;
      assign in_ready   = !reset && (!s0_valid || s0_advance);

      // Only the immediate-bearing bits travel on; the opcode is already folded into s0_fmt.
      always_ff @(posedge clk) begin
        if (reset) begin
          s0_valid   <= 1'b0;
          s0_fmt     <= FMT_NONE;
          s0_payload <= '0;
        end else if (in_valid && in_ready) begin
          s0_valid   <= 1'b1;
          s0_fmt     <= dec_fmt;
          s0_payload <= instruction[25:0];
        end else if (s0_advance) begin
          s0_valid   <= 1'b0;
        end
      end

      assign ext_fmt     = s0_fmt;
      assign ext_payload = s0_payload;
      assign fin_src_vld = s0_valid;
    end else begin : g_one_stage
      assign in_ready    = !reset && out_adv;
      assign ext_fmt     = dec_fmt;
      assign ext_payload = instruction[25:0];
      assign fin_src_vld = in_valid && in_ready;
    end
  endgenerate

  always_comb begin
    ext_imm = '0;
    ext_ill = 1'b0;
    case (ext_fmt)
      FMT_B: begin
        ext_imm = {{(WORD-26){ext_payload[25]}}, ext_payload[25:0]};
        if (SHIFT_BRANCH != 0) ext_imm = ext_imm << 2;
      end
      FMT_CB: begin
        ext_imm = {{(WORD-19){ext_payload[23]}}, ext_payload[23:5]};
        if (SHIFT_BRANCH != 0) ext_imm = ext_imm << 2;
      end
      FMT_D:  ext_imm = {{(WORD-9){ext_payload[20]}}, ext_payload[20:12]};
      FMT_I:  ext_imm = {{(WORD-12){1'b0}}, ext_payload[21:10]};
      FMT_IW: begin
        if (iw_fits(ext_payload[22:21], WORD))
          ext_imm = {{(WORD-16){1'b0}}, ext_payload[20:5]} << {ext_payload[22:21], 4'b0000};
        else
          ext_ill = 1'b1;
      end
      default: ext_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      imm_out   <= '0;
      fmt_out   <= FMT_NONE;
      illegal   <= 1'b0;
    end else if (out_adv) begin
      out_valid <= fin_src_vld;
      if (fin_src_vld) begin
        imm_out <= ext_imm;
        fmt_out <= ext_fmt;
        illegal <= ext_ill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      illegal_count <= '0;
    else if (out_valid && out_ready && illegal && (illegal_count != '1))
      illegal_count <= illegal_count + 1'b1;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 2-stage word-offset instance and a 1-stage byte-offset, 2-bit-counter
// instance, checked against a reference model and hand-computed immediates.
module tb_imm_gen_pipe;

  typedef struct {
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instruction;
  logic [63:0] imm_out;
  logic [2:0]  fmt_out;
  logic [15:0] illegal_count;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, illegal1;
  logic [31:0] instruction1;
  logic [63:0] imm_out1;
  logic [2:0]  fmt_out1;
  logic [1:0]  illegal_count1;

  int          nchecks = 0;
  int          nfail   = 0;
  int          exp_cnt = 0;
  res_t        expq[$];
  logic [31:0] stim_q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.INSTR_LEN(32), .WORD(64), .STAGES(2), .SHIFT_BRANCH(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .fmt_out(fmt_out), .illegal(illegal), .illegal_count(illegal_count)
  );

  imm_gen_pipe #(.INSTR_LEN(32), .WORD(64), .STAGES(1), .SHIFT_BRANCH(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .instruction(instruction1), .out_valid(out_valid1), .out_ready(out_ready1),
    .imm_out(imm_out1), .fmt_out(fmt_out1), .illegal(illegal1), .illegal_count(illegal_count1)
  );

  // Reference: format by opcode table, immediate by signed arithmetic at 64 bits.
  function automatic res_t model(input logic [31:0] ins, input bit sb);
    res_t r;
    longint scale;
    scale = sb ? 64'sd4 : 64'sd1;
    r.fmt = 3'd0; r.imm = 64'd0; r.ill = 1'b1;
    if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
      r.fmt = 3'd1; r.ill = 1'b0; r.imm = longint'($signed(ins[25:0])) * scale;
    end else if (ins[31:24] == 8'hB4 || ins[31:24] == 8'hB5 || ins[31:24] == 8'h54) begin
      r.fmt = 3'd2; r.ill = 1'b0; r.imm = longint'($signed(ins[23:5])) * scale;
    end else if (ins[31:21] == 11'b11111000010 || ins[31:21] == 11'b11111000000) begin
      r.fmt = 3'd3; r.ill = 1'b0; r.imm = longint'($signed(ins[20:12]));
    end else if (ins[31:22] == 10'b1001000100 || ins[31:22] == 10'b1101000100 ||
                 ins[31:22] == 10'b1001001000 || ins[31:22] == 10'b1011001000) begin
      r.fmt = 3'd4; r.ill = 1'b0; r.imm = 64'(ins[21:10]);
    end else if (ins[31:23] == 9'b110100101) begin
      r.fmt = 3'd5; r.ill = 1'b0; r.imm = 64'(ins[20:5]) * (64'd1 << (16 * int'(ins[22:21])));
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[31:26] = ($urandom_range(0, 1) != 0) ? 6'b000101 : 6'b100101;
      1: case ($urandom_range(0, 2))
           0: r[31:24] = 8'hB4;
           1: r[31:24] = 8'hB5;
           default: r[31:24] = 8'h54;
         endcase
      2: r[31:21] = ($urandom_range(0, 1) != 0) ? 11'b11111000010 : 11'b11111000000;
      3: case ($urandom_range(0, 3))
           0: r[31:22] = 10'b1001000100;
           1: r[31:22] = 10'b1101000100;
           2: r[31:22] = 10'b1001001000;
           default: r[31:22] = 10'b1011001000;
         endcase
      4: r[31:23] = 9'b110100101;
      5: r = 32'h0;
      default: ;
    endcase
    return r;
  endfunction

  // Driver for dut: one transfer, returns what appears at the output (ok=0 on timeout).
  task automatic xfer(input logic [31:0] ins, output logic [2:0] f, output logic [63:0] im,
                      output logic il, output bit ok);
    int k;
    @(negedge clk); in_valid = 1'b1; instruction = ins; out_ready = 1'b1; #1;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); #1; k++; end
    @(negedge clk); in_valid = 1'b0; #1;
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); #1; k++; end
    ok = out_valid; f = fmt_out; im = imm_out; il = illegal;
  endtask

  // Driver for dut1: presents one item for one cycle, samples the cycle after.
  task automatic send1(input logic [31:0] ins, output logic acc, output logic ov,
                       output logic [63:0] im, output logic il);
    @(negedge clk); in_valid1 = 1'b1; instruction1 = ins; out_ready1 = 1'b1; #1;
    acc = in_ready1;
    @(negedge clk); in_valid1 = 1'b0; #1;
    ov = out_valid1; im = imm_out1; il = illegal1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; instruction = 32'hF85F8041; out_ready = 1'b1;
    in_valid1 = 1'b1; instruction1 = 32'hF85F8041; out_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    nchecks++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    nchecks++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nchecks++; if (imm_out !== 64'd0) begin nfail++; $display("FAIL reset_imm: got %h want 0", imm_out); end
    nchecks++; if (fmt_out !== 3'd0 || illegal !== 1'b0) begin nfail++; $display("FAIL reset_fmt_ill: got %0d/%b want 0/0", fmt_out, illegal); end
    nchecks++; if (illegal_count !== 16'd0 || illegal_count1 !== 2'd0) begin nfail++; $display("FAIL reset_count: got %0d/%0d want 0/0", illegal_count, illegal_count1); end
    reset = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    nchecks++; if (out_valid !== 1'b0 || out_valid1 !== 1'b0) begin nfail++; $display("FAIL reset_input_dropped: got %b/%b want 0/0", out_valid, out_valid1); end
  endtask

  task automatic test_ldur_latency();
    @(negedge clk); in_valid = 1'b1; instruction = 32'hF85F8041; out_ready = 1'b1; #1;
    nchecks++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL ldur_accept: in_ready %b want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    nchecks++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL ldur_early: out_valid %b want 0 after 1 cycle", out_valid); end
    @(negedge clk); #1;
    nchecks++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL ldur_latency: out_valid %b want 1 after 2 cycles", out_valid); end
    nchecks++; if (fmt_out !== 3'd3 || imm_out !== 64'hFFFFFFFFFFFFFFF8 || illegal !== 1'b0) begin
      nfail++; $display("FAIL ldur_value: fmt %0d imm %h ill %b want 3 fffffffffffffff8 0", fmt_out, imm_out, illegal);
    end
    @(negedge clk);
  endtask

  task automatic test_formats();
    logic [2:0] f; logic [63:0] im; logic il; bit ok;
    xfer(32'hB4FFFF83, f, im, il, ok);
    nchecks++; if (!ok || f !== 3'd2 || im !== 64'hFFFFFFFFFFFFFFFC || il !== 1'b0) begin
      nfail++; $display("FAIL cbz_word: ok %0d fmt %0d imm %h ill %b want 1 2 fffffffffffffffc 0", ok, f, im, il);
    end
    xfer(32'hD2D7DDE0, f, im, il, ok);
    nchecks++; if (!ok || f !== 3'd5 || im !== 64'h0000BEEF00000000 || il !== 1'b0) begin
      nfail++; $display("FAIL movz: ok %0d fmt %0d imm %h ill %b want 1 5 0000beef00000000 0", ok, f, im, il);
    end
    xfer(32'h913FFC21, f, im, il, ok);
    nchecks++; if (!ok || f !== 3'd4 || im !== 64'h0000000000000FFF || il !== 1'b0) begin
      nfail++; $display("FAIL addi: ok %0d fmt %0d imm %h ill %b want 1 4 fff 0", ok, f, im, il);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [2:0] f; logic [63:0] im; logic il; bit ok;
    for (int i = 0; i < 3; i++) begin
      xfer(32'h00000000, f, im, il, ok);
      nchecks++; if (!ok || f !== 3'd0 || im !== 64'd0 || il !== 1'b1) begin
        nfail++; $display("FAIL illegal_%0d: ok %0d fmt %0d imm %h ill %b want 1 0 0 1", i, ok, f, im, il);
      end
    end
    @(negedge clk); #1;
    nchecks++; if (illegal_count !== 16'd3) begin nfail++; $display("FAIL illegal_count: got %0d want 3", illegal_count); end
    exp_cnt = 3;
  endtask

  task automatic test_stage1_shift();
    logic acc, ov, il; logic [63:0] im;
    send1(32'hB4FFFF83, acc, ov, im, il);
    nchecks++; if (acc !== 1'b1 || ov !== 1'b1 || im !== 64'hFFFFFFFFFFFFFFF0 || il !== 1'b0) begin
      nfail++; $display("FAIL cbz_byte: acc %b ov %b imm %h ill %b want 1 1 fffffffffffffff0 0", acc, ov, im, il);
    end
    send1(32'h17FFFFFF, acc, ov, im, il);
    nchecks++; if (acc !== 1'b1 || ov !== 1'b1 || im !== 64'hFFFFFFFFFFFFFFFC || fmt_out1 !== 3'd1) begin
      nfail++; $display("FAIL b_byte: acc %b ov %b imm %h fmt %0d want 1 1 fffffffffffffffc 1", acc, ov, im, fmt_out1);
    end
    send1(32'h14000005, acc, ov, im, il);
    nchecks++; if (ov !== 1'b1 || im !== 64'd20) begin nfail++; $display("FAIL b_pos_byte: ov %b imm %h want 1 14", ov, im); end
  endtask

  task automatic test_count_saturate();
    logic acc, ov, il; logic [63:0] im;
    for (int i = 1; i <= 5; i++) begin
      send1(32'h00000000, acc, ov, im, il);
      @(negedge clk); #1;
      nchecks++; if (illegal_count1 !== 2'((i > 3) ? 3 : i)) begin
        nfail++; $display("FAIL count_sat_%0d: got %0d want %0d", i, illegal_count1, (i > 3) ? 3 : i);
      end
    end
  endtask

  // mode 0: always-valid with out_ready low on cycles 3-6; mode 1: random valid and ready.
  task automatic run_stream(input int n, input int mode, input string name);
    int   sent, got, cyc;
    bit   prev_stall, seen_block;
    res_t e;
    logic [63:0] p_imm; logic [2:0] p_fmt; logic p_ill;
    sent = 0; got = 0; cyc = 0; prev_stall = 0; seen_block = 0;
    p_imm = '0; p_fmt = '0; p_ill = 1'b0;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      out_ready = (mode == 0) ? !(cyc >= 3 && cyc <= 6) : ($urandom_range(0, 9) < 7);
      if (sent < n && (mode == 0 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1; instruction = stim_q[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        nchecks++; if (out_valid !== 1'b1 || imm_out !== p_imm || fmt_out !== p_fmt || illegal !== p_ill) begin
          nfail++; $display("FAIL %s_hold cyc %0d: v %b imm %h fmt %0d ill %b want 1 %h %0d %b", name, cyc, out_valid, imm_out, fmt_out, illegal, p_imm, p_fmt, p_ill);
        end
      end
      nchecks++; if (in_ready !== ((sent - got) < 2 || out_ready)) begin
        nfail++; $display("FAIL %s_in_ready cyc %0d: got %b want %b (held %0d)", name, cyc, in_ready, ((sent - got) < 2 || out_ready), sent - got);
      end
      if (!in_ready) seen_block = 1;
      if (out_valid && out_ready) begin
        nchecks++;
        if (expq.size() == 0) begin
          nfail++; $display("FAIL %s_spurious cyc %0d: output with nothing outstanding", name, cyc);
        end else begin
          e = expq.pop_front();
          if (fmt_out !== e.fmt || imm_out !== e.imm || illegal !== e.ill) begin
            nfail++; $display("FAIL %s_data item %0d: fmt %0d imm %h ill %b want %0d %h %b", name, got, fmt_out, imm_out, illegal, e.fmt, e.imm, e.ill);
          end
          if (e.ill && exp_cnt < 65535) exp_cnt++;
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      p_imm = imm_out; p_fmt = fmt_out; p_ill = illegal;
      if (in_valid && in_ready) begin
        expq.push_back(model(instruction, 1'b0));
        sent++;
      end
      cyc++;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
    nchecks++; if (got != n || expq.size() != 0) begin nfail++; $display("FAIL %s_complete: got %0d of %0d, %0d left", name, got, n, expq.size()); end
    nchecks++; if (illegal_count !== 16'(exp_cnt)) begin nfail++; $display("FAIL %s_count: got %0d want %0d", name, illegal_count, exp_cnt); end
    if (mode == 0) begin
      nchecks++; if (!seen_block) begin nfail++; $display("FAIL %s_backpressure: in_ready never dropped", name); end
    end
  endtask

  task automatic test_back_to_back();
    stim_q.delete();
    stim_q.push_back(32'hF85F8041); stim_q.push_back(32'hB4FFFF83);
    stim_q.push_back(32'hD2D7DDE0); stim_q.push_back(32'h913FFC21);
    stim_q.push_back(32'h00000000); stim_q.push_back(32'h17FFFFFF);
    stim_q.push_back(32'hF81FF3E2); stim_q.push_back(32'h54000041);
    run_stream(8, 0, "b2b");
  endtask

  task automatic test_random();
    stim_q.delete();
    for (int i = 0; i < 300; i++) stim_q.push_back(rand_instr());
    run_stream(300, 1, "rand");
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; instruction = 32'h00000000;
    @(negedge clk); instruction = 32'hF85F8041;
    @(negedge clk); in_valid = 1'b0; #1;
    nchecks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin nfail++; $display("FAIL midflight_setup: v %b rdy %b want 1 0", out_valid, in_ready); end
    reset = 1'b1;
    @(negedge clk); #1;
    nchecks++; if (out_valid !== 1'b0 || illegal_count !== 16'd0 || in_ready !== 1'b0) begin
      nfail++; $display("FAIL midflight_reset: v %b cnt %0d rdy %b want 0 0 0", out_valid, illegal_count, in_ready);
    end
    reset = 1'b0; out_ready = 1'b1; exp_cnt = 0;
    repeat (3) @(negedge clk);
    #1;
    nchecks++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL midflight_flushed: out_valid %b want 0", out_valid); end
    stim_q.delete();
    for (int i = 0; i < 40; i++) stim_q.push_back(rand_instr());
    run_stream(40, 1, "resume");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ldur_latency();
    test_illegal();
    test_formats();
    test_stage1_shift();
    test_count_saturate();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
